// File: rtl/tt_pkg.sv
// Shared widths, edge record and FSM state encoding for the TT frame loader.
package tt_pkg;

    localparam int NODE_W = 4;
    localparam int COST_W = 4;
    localparam int BYTE_W = 8;

    typedef struct packed {
        logic [NODE_W-1:0] a;
        logic [NODE_W-1:0] b;
    } edge_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_EDGES,
        S_DRIVE,
        S_WAIT,
        S_RESULT
    } state_t;

endpackage

// File: rtl/tt_edge_buf.sv
// Single-clock edge buffer: synchronous write, registered read with write-through
// so an edge written on the final frame beat is readable on the very next cycle.
module tt_edge_buf
    import tt_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [BYTE_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [BYTE_W-1:0] o_rd_data
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [BYTE_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en && (i_wr_addr < AW'(DEPTH)))
            r_mem[i_wr_addr[IW-1:0]] <= i_wr_data;
        if (i_wr_en && (i_wr_addr == i_rd_addr))
            r_rd_data <= i_wr_data;
        else if (i_rd_addr < AW'(DEPTH))
            r_rd_data <= r_mem[i_rd_addr[IW-1:0]];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tt_frame_loader.sv
// Buffers a byte-serial query frame, replays it to the TT core as one burst and returns the cost.
// Optional build macro TT_EDGE_FILTER_EN drops self-loops and duplicate edges before storage.
module tt_frame_loader
    import tt_pkg::*;
#(
    parameter int MAX_EDGES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_byte_valid,
    output logic              in_byte_ready,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              tt_in_valid,
    output logic [NODE_W-1:0] tt_source,
    output logic [NODE_W-1:0] tt_destination,
    input  logic              tt_out_valid,
    input  logic [COST_W-1:0] tt_cost,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [COST_W-1:0] res_cost,
    output logic              res_unreach,
    output logic              res_err,
    output logic              busy
);

    localparam int PW = $clog2(MAX_EDGES + 1);
    localparam logic [BYTE_W:0] MAX_N = (BYTE_W+1)'(MAX_EDGES);

    state_t            r_state, w_state_nxt;
    logic              w_acc, w_store, w_keep, w_last;
    logic [BYTE_W-1:0] r_query, r_n, r_rx_cnt, w_rx_nxt, w_rd_data;
    logic [PW-1:0]     r_wr_cnt, w_wr_nxt, r_rd_ptr, r_drv_left;
    logic              r_err;
    logic              r_tt_in_valid, r_res_valid, r_res_unreach, r_res_err;
    logic [NODE_W-1:0] r_tt_src, r_tt_dst;
    logic [COST_W-1:0] r_res_cost;
    edge_t             w_in_edge, w_rd_edge, w_query_edge;

    assign w_in_edge    = in_byte;
    assign w_rd_edge    = w_rd_data;
    assign w_query_edge = r_query;
    assign w_acc        = in_byte_valid && in_byte_ready;
    assign w_rx_nxt     = r_rx_cnt + 8'd1;
    assign w_last       = (w_rx_nxt == r_n);
    assign w_store      = (r_state == S_EDGES) && w_acc && (r_wr_cnt < PW'(MAX_EDGES)) && w_keep;
    assign w_wr_nxt     = r_wr_cnt + {{(PW-1){1'b0}}, w_store};

`ifdef TT_EDGE_FILTER_EN
    // Seen-bitmap indexed by {a,b}; both orientations are probed so b->a matches a->b.
    logic [255:0] r_seen;

    assign w_keep = (w_in_edge.a != w_in_edge.b) &&
                    !r_seen[{w_in_edge.a, w_in_edge.b}] &&
                    !r_seen[{w_in_edge.b, w_in_edge.a}];

    always_ff @(posedge clk) begin
        if (rst || (r_state == S_IDLE))
            r_seen <= '0;
        else if ((r_state == S_EDGES) && w_acc && w_keep)
            r_seen[{w_in_edge.a, w_in_edge.b}] <= 1'b1;
    end
`else
    assign w_keep = 1'b1;
`endif

    tt_edge_buf #(
        .DEPTH (MAX_EDGES),
        .AW    (PW)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_store),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data (in_byte),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        in_byte_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_byte_ready = 1'b1;
                if (w_acc) w_state_nxt = S_LEN;
            end
            S_LEN: begin
                in_byte_ready = 1'b1;
                if (w_acc) w_state_nxt = (in_byte == '0) ? S_DRIVE : S_EDGES;
            end
            S_EDGES: begin
                in_byte_ready = 1'b1;
                if (w_acc && w_last) w_state_nxt = S_DRIVE;
            end
            S_DRIVE:  if (r_drv_left == '0) w_state_nxt = S_WAIT;
            S_WAIT:   if (tt_out_valid) w_state_nxt = S_RESULT;
            S_RESULT: if (res_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Entering S_DRIVE: query goes out first while the buffer already presents edge 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_query       <= '0;
            r_n           <= '0;
            r_rx_cnt      <= '0;
            r_wr_cnt      <= '0;
            r_rd_ptr      <= '0;
            r_drv_left    <= '0;
            r_err         <= 1'b0;
            r_tt_in_valid <= 1'b0;
            r_tt_src      <= '0;
            r_tt_dst      <= '0;
            r_res_valid   <= 1'b0;
            r_res_cost    <= '0;
            r_res_unreach <= 1'b0;
            r_res_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rx_cnt <= '0;
                    r_wr_cnt <= '0;
                    r_rd_ptr <= '0;
                    r_err    <= 1'b0;
                    if (w_acc) r_query <= in_byte;
                end
                S_LEN: begin
                    if (w_acc) begin
                        r_n   <= in_byte;
                        r_err <= ({1'b0, in_byte} > MAX_N);
                        if (in_byte == '0) begin
                            r_tt_in_valid <= 1'b1;
                            r_tt_src      <= w_query_edge.a;
                            r_tt_dst      <= w_query_edge.b;
                            r_drv_left    <= '0;
                            r_rd_ptr      <= PW'(1);
                        end
                    end
                end
                S_EDGES: begin
                    if (w_acc) begin
                        r_rx_cnt <= w_rx_nxt;
                        r_wr_cnt <= w_wr_nxt;
                        if (w_last) begin
                            r_tt_in_valid <= 1'b1;
                            r_tt_src      <= w_query_edge.a;
                            r_tt_dst      <= w_query_edge.b;
                            r_drv_left    <= w_wr_nxt;
                            r_rd_ptr      <= PW'(1);
                        end
                    end
                end
                S_DRIVE: begin
                    if (r_drv_left != '0) begin
                        r_tt_src   <= w_rd_edge.a;
                        r_tt_dst   <= w_rd_edge.b;
                        r_drv_left <= r_drv_left - PW'(1);
                        r_rd_ptr   <= r_rd_ptr + PW'(1);
                    end else begin
                        r_tt_in_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (tt_out_valid) begin
                        r_res_valid   <= 1'b1;
                        r_res_cost    <= tt_cost;
                        r_res_unreach <= (tt_cost == '0);
                        r_res_err     <= r_err;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_valid   <= 1'b0;
                        r_res_cost    <= '0;
                        r_res_unreach <= 1'b0;
                        r_res_err     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tt_in_valid    = r_tt_in_valid;
    assign tt_source      = r_tt_src;
    assign tt_destination = r_tt_dst;
    assign res_valid      = r_res_valid;
    assign res_cost       = r_res_cost;
    assign res_unreach    = r_res_unreach;
    assign res_err        = r_res_err;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_tt_frame_loader.sv
// Directed bench for tt_frame_loader: frame replay, result handshake, truncation, reset and filtering.
module tb_tt_frame_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_byte_valid, in_byte_ready;
    logic [7:0] in_byte;
    logic       tt_in_valid;
    logic [3:0] tt_source, tt_destination;
    logic       tt_out_valid;
    logic [3:0] tt_cost;
    logic       res_valid, res_ready;
    logic [3:0] res_cost;
    logic       res_unreach, res_err, busy;

    always #5 clk = ~clk;

    tt_frame_loader #(.MAX_EDGES(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_byte_valid  (in_byte_valid),
        .in_byte_ready  (in_byte_ready),
        .in_byte        (in_byte),
        .tt_in_valid    (tt_in_valid),
        .tt_source      (tt_source),
        .tt_destination (tt_destination),
        .tt_out_valid   (tt_out_valid),
        .tt_cost        (tt_cost),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_cost       (res_cost),
        .res_unreach    (res_unreach),
        .res_err        (res_err),
        .busy           (busy)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] fr_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] drv_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (tt_in_valid === 1'b1) drv_q.push_back({tt_source, tt_destination});

    task automatic send_frame(input string tag);
        int bad = 0;
        drv_q.delete();
        foreach (fr_q[i]) begin
            in_byte_valid = 1'b1;
            in_byte       = fr_q[i];
            if (in_byte_ready !== 1'b1) bad++;
            if (tt_in_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        in_byte_valid = 1'b0;
        check({tag, "_rx_ready"}, bad, 0);
        check({tag, "_drive_start"}, tt_in_valid, 1);
    endtask

    task automatic finish_drive(input string tag);
        int guard = 0;
        while (tt_in_valid === 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_drive_timeout"}, guard >= 200, 0);
        check({tag, "_drive_len"}, drv_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < drv_q.size(); i++)
            check($sformatf("%s_drive_%0d", tag, i), drv_q[i], exp_q[i]);
    endtask

    task automatic respond(input string tag, input logic [3:0] cost);
        @(posedge clk); #1;
        check({tag, "_wait_busy"}, busy, 1);
        check({tag, "_wait_novalid"}, {tt_in_valid, res_valid}, 0);
        tt_out_valid = 1'b1;
        tt_cost      = cost;
        @(posedge clk); #1;
        tt_out_valid = 1'b0;
        check({tag, "_res_valid"}, res_valid, 1);
    endtask

    task automatic release_res(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_res_drop"}, {res_valid, busy}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_byte_valid = 1'b0; in_byte = '0;
        tt_out_valid = 1'b0; tt_cost = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {tt_in_valid, res_valid, res_cost, res_unreach, res_err, busy}, 0);
        rst = 1'b0;
        check("reset_ready", in_byte_ready, 1);

        // T1: three edges, cost 3
        fr_q  = '{8'h03, 8'h03, 8'h01, 8'h12, 8'h23};
        exp_q = '{8'h03, 8'h01, 8'h12, 8'h23};
        send_frame("t1");
        finish_drive("t1");
        respond("t1", 4'd3);
        check("t1_result", {res_cost, res_unreach, res_err}, {4'd3, 1'b0, 1'b0});
        release_res("t1");

        // T2: empty edge list, single drive cycle
        fr_q  = '{8'h55, 8'h00};
        exp_q = '{8'h55};
        send_frame("t2");
        finish_drive("t2");
        respond("t2", 4'd9);
        check("t2_result", {res_cost, res_unreach, res_err}, {4'd9, 1'b0, 1'b0});
        release_res("t2");

        // T3: 40 distinct edges, truncated to 32, unreachable result
        fr_q  = '{8'h1F, 8'd40};
        exp_q = '{8'h1F};
        for (int a = 0; a < 16 && fr_q.size() < 42; a++)
            for (int b = a + 1; b < 16 && fr_q.size() < 42; b++) begin
                fr_q.push_back({a[3:0], b[3:0]});
                if (exp_q.size() < 33) exp_q.push_back({a[3:0], b[3:0]});
            end
        send_frame("t3");
        finish_drive("t3");
        respond("t3", 4'd0);
        check("t3_result", {res_cost, res_unreach, res_err}, {4'd0, 1'b1, 1'b1});
        release_res("t3");

        // T4: result held under back-pressure, input stays closed
        fr_q  = '{8'h2A, 8'h01, 8'h21};
        exp_q = '{8'h2A, 8'h21};
        send_frame("t4");
        finish_drive("t4");
        respond("t4", 4'd5);
        in_byte_valid = 1'b1;
        in_byte       = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("t4_hold_%0d", i), {res_valid, res_cost, in_byte_ready}, {1'b1, 4'd5, 1'b0});
        end
        in_byte_valid = 1'b0;
        release_res("t4");

        // T5: reset on the third drive cycle, then a stray core result
        fr_q  = '{8'h03, 8'h03, 8'h01, 8'h12, 8'h23};
        send_frame("t5");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_third_cycle", tt_in_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_after_rst", {tt_in_valid, busy, res_valid}, 0);
        tt_out_valid = 1'b1;
        tt_cost      = 4'd7;
        @(posedge clk); #1;
        tt_out_valid = 1'b0;
        @(posedge clk); #1;
        check("t5_stray", {res_valid, busy, tt_in_valid, in_byte_ready}, 4'b0001);

        // T6: self-loop and reversed duplicate
        fr_q  = '{8'h05, 8'h04, 8'h12, 8'h21, 8'h33, 8'h45};
`ifdef TT_EDGE_FILTER_EN
        exp_q = '{8'h05, 8'h12, 8'h45};
`else
        exp_q = '{8'h05, 8'h12, 8'h21, 8'h33, 8'h45};
`endif
        send_frame("t6");
        finish_drive("t6");
        respond("t6", 4'd2);
        check("t6_result", {res_cost, res_unreach, res_err}, {4'd2, 1'b0, 1'b0});
        release_res("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
